// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, keeps at most one request in flight to
// instruction memory, and hands fetched words to decode over valid/ready.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_FETCH  | requesting imem at pc (unless a halt is pending)
//  S_WAIT   | request granted, waiting for imem_rvalid
//  S_HOLD   | instruction presented to decode, waiting for instr_ready
//  S_HALTED | terminal until reset; pc frozen, no requests
module fetch_sequencer #(
   parameter int unsigned            ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
   parameter int unsigned            PC_STEP      = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  halt_request,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_target,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [31:0]           imem_rdata,
   output logic                  instr_valid,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic [31:0]           instr_data,
   input  logic                  instr_ready,
   output logic [ADDR_WIDTH-1:0] pc_value,
   output logic                  halted
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_WAIT   = 2'd1,
      S_HOLD   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] pc;
   logic                  kill;
   logic                  halt_pending;
   logic                  fetch_req;
   logic [ADDR_WIDTH-1:0] redirect_pc;

   assign redirect_pc = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
   assign fetch_req   = (state == S_FETCH) && !halt_pending;

   // Reset is synchronous, so the request is also masked combinationally
   // to keep it low during the reset cycle itself.
   assign imem_req    = fetch_req && !reset;
   assign imem_addr   = pc;
   assign instr_valid = (state == S_HOLD);
   assign halted      = (state == S_HALTED);
   assign pc_value    = pc;

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= S_FETCH;
         pc           <= RESET_VECTOR;
         kill         <= 1'b0;
         halt_pending <= 1'b0;
         instr_pc     <= '0;
         instr_data   <= '0;
      end else begin
         if (halt_request)
            halt_pending <= 1'b1;

         unique case (state)
            S_FETCH: begin
               if (redirect_valid) begin
                  pc <= redirect_pc;
                  if (imem_gnt && fetch_req) begin
                     state <= S_WAIT;
                     kill  <= 1'b1;
                  end
               end else if (halt_pending) begin
                  state <= S_HALTED;
               end else if (imem_gnt) begin
                  state <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (imem_rvalid) begin
                  if (redirect_valid || kill) begin
                     if (redirect_valid)
                        pc <= redirect_pc;
                     kill  <= 1'b0;
                     state <= S_FETCH;
                  end else begin
                     instr_data <= imem_rdata;
                     instr_pc   <= pc;
                     pc         <= pc + ADDR_WIDTH'(PC_STEP);
                     state      <= S_HOLD;
                  end
               end else if (redirect_valid) begin
                  // Response for the old path is still owed; drop it on arrival.
                  pc   <= redirect_pc;
                  kill <= 1'b1;
               end
            end

            S_HOLD: begin
               if (redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= S_FETCH;
               end else if (instr_ready) begin
                  state <= halt_pending ? S_HALTED : S_FETCH;
               end
            end

            S_HALTED: begin
               state <= S_HALTED;
            end

            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a memory responder answers requests, expected
// deliveries are queued by the stimulus and checked by an independent monitor.
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic        halt_request;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic [31:0] instr_data;
   logic        instr_ready;
   logic [31:0] pc_value;
   logic        halted;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   bit          gnt_on   = 1'b1;
   int          lat      = 1;
   int          rsp_cnt  = 0;
   logic [31:0] rsp_addr = '0;

   fetch_sequencer #(
      .ADDR_WIDTH   (32),
      .RESET_VECTOR (32'h0000_0000),
      .PC_STEP      (4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .halt_request    (halt_request),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_gnt        (imem_gnt),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .instr_valid     (instr_valid),
      .instr_pc        (instr_pc),
      .instr_data      (instr_data),
      .instr_ready     (instr_ready),
      .pc_value        (pc_value),
      .halted          (halted)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   task automatic push(input logic [31:0] pc);
      exp_t e;
      e.pc   = pc;
      e.data = mem_word(pc);
      exp_q.push_back(e);
   endtask

   task automatic next_drive();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!instr_valid && n < 40);
      if (!instr_valid) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: instr_valid never rose within 40 cycles", name);
      end
   endtask

   task automatic do_reset(input bit g);
      gnt_on = 1'b0;
      next_drive();
      reset = 1'b1;
      next_drive();
      next_drive();
      reset  = 1'b0;
      gnt_on = g;
   endtask

   // Memory responder: one outstanding request, response 'lat' cycles after grant.
   initial begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clock);
         imem_rvalid = 1'b0;
         if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(rsp_addr);
            end
         end
         imem_gnt = 1'b0;
         if (imem_req && gnt_on && rsp_cnt == 0) begin
            imem_gnt = 1'b1;
            rsp_addr = imem_addr;
            rsp_cnt  = lat;
         end
      end
   end

   // Monitor: every consumed instruction must match the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && instr_valid && instr_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_delivery: got pc %h data %h, expected no delivery",
                        instr_pc, instr_data);
            end else begin
               e = exp_q.pop_front();
               check("deliv_pc", instr_pc, e.pc);
               check("deliv_data", instr_data, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset           = 1'b1;
      halt_request    = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      instr_ready     = 1'b1;

      // reset state
      @(posedge clock);
      @(negedge clock);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_pc", pc_value, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_instr_data", instr_data, 32'h0);

      // back-to-back fetch with immediate grant
      push(32'h0);
      push(32'h4);
      push(32'h8);
      next_drive();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_valid("seq_valid");
         check("seq_pc_value", pc_value, 32'(4 * (i + 1)));
      end

      // grant withheld for 3 cycles
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("nogrant_req", 32'(imem_req), 32'd1);
         check("nogrant_addr", imem_addr, 32'h0);
         check("nogrant_valid", 32'(instr_valid), 32'd0);
      end
      next_drive();
      gnt_on = 1'b1;
      push(32'h0);
      wait_valid("nogrant_deliver");

      // redirect during WAIT
      do_reset(1'b1);
      lat = 3;
      next_drive();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0103;
      next_drive();
      redirect_valid = 1'b0;
      push(32'h100);
      @(negedge clock);
      check("wait_redir_pc", pc_value, 32'h100);
      begin
         int n;
         n = 0;
         do begin
            @(negedge clock);
            n++;
         end while (!imem_req && n < 20);
      end
      check("wait_redir_req", 32'(imem_req), 32'd1);
      check("wait_redir_addr", imem_addr, 32'h100);
      wait_valid("wait_redir_deliver");
      check("wait_redir_instr_pc", instr_pc, 32'h100);

      // HOLD with backpressure, then squash by redirect
      do_reset(1'b1);
      lat         = 1;
      instr_ready = 1'b0;
      wait_valid("hold_valid");
      for (int k = 0; k < 4; k++) begin
         check("hold_valid_stable", 32'(instr_valid), 32'd1);
         check("hold_pc_stable", instr_pc, 32'h0);
         check("hold_data_stable", instr_data, mem_word(32'h0));
         check("hold_no_req", 32'(imem_req), 32'd0);
         if (k < 3) @(negedge clock);
      end
      next_drive();
      instr_ready     = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0200;
      push(32'h200);
      next_drive();
      redirect_valid = 1'b0;
      @(negedge clock);
      check("squash_valid", 32'(instr_valid), 32'd0);
      check("squash_req", 32'(imem_req), 32'd1);
      check("squash_addr", imem_addr, 32'h200);
      wait_valid("squash_deliver");

      // halt during WAIT
      do_reset(1'b1);
      lat = 2;
      next_drive();
      halt_request = 1'b1;
      push(32'h0);
      next_drive();
      halt_request = 1'b0;
      wait_valid("halt_deliver");
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         check("halt_halted", 32'(halted), 32'd1);
         check("halt_no_req", 32'(imem_req), 32'd0);
         check("halt_no_valid", 32'(instr_valid), 32'd0);
      end
      next_drive();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0300;
      next_drive();
      redirect_valid = 1'b0;
      @(negedge clock);
      check("halt_redir_pc", pc_value, 32'h4);
      check("halt_redir_halted", 32'(halted), 32'd1);
      do_reset(1'b1);
      lat = 1;
      push(32'h0);
      @(negedge clock);
      check("halt_rst_halted", 32'(halted), 32'd0);
      check("halt_rst_req", 32'(imem_req), 32'd1);
      check("halt_rst_addr", imem_addr, 32'h0);
      wait_valid("halt_rst_deliver");

      // pc wrap, then reset with a response still in flight
      do_reset(1'b0);
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      push(32'hFFFF_FFFC);
      next_drive();
      redirect_valid = 1'b0;
      gnt_on         = 1'b1;
      lat            = 1;
      @(negedge clock);
      check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      wait_valid("wrap_deliver");
      check("wrap_pc_value", pc_value, 32'h0);
      lat = 4;
      @(negedge clock);
      check("wrap_next_req", 32'(imem_req), 32'd1);
      check("wrap_next_addr", imem_addr, 32'h0);
      next_drive();
      reset = 1'b1;
      next_drive();
      reset = 1'b0;
      push(32'h0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("stale_no_valid", 32'(instr_valid), 32'd0);
         if (k == 0) check("stale_restart_addr", imem_addr, 32'h0);
      end
      wait_valid("stale_deliver");

      repeat (3) @(negedge clock);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
